// File: rtl/dpd_lms_adapt_if.sv
// Signal bundle between the DPD LMS adaptation engine and its surroundings:
// run control, training/feedback samples, basis vectors and the coefficient bank.
interface dpd_lms_adapt_if #(
    parameter int W     = 20,
    parameter int CW    = 20,
    parameter int NCOEF = 15
);
    logic                  start;
    logic [3:0]            n_iter;
    logic [4:0]            mu_shift;
    logic                  clear_coef;
    logic signed [W-1:0]   ref_i, ref_q, fb_i, fb_q;
    logic [NCOEF*W-1:0]    yy_i, yy_q;
    logic [NCOEF*CW-1:0]   coef_i, coef_q;
    logic                  train_en, sw_fb, busy, done;
    logic [3:0]            iter_cnt;

    modport master (
        output start, n_iter, mu_shift, clear_coef, ref_i, ref_q, fb_i, fb_q, yy_i, yy_q,
        input  coef_i, coef_q, train_en, sw_fb, busy, done, iter_cnt
    );

    modport slave (
        input  start, n_iter, mu_shift, clear_coef, ref_i, ref_q, fb_i, fb_q, yy_i, yy_q,
        output coef_i, coef_q, train_en, sw_fb, busy, done, iter_cnt
    );
endinterface

// File: rtl/dpd_lms_adapt.sv
// LMS coefficient-adaptation engine for the memory-polynomial DPD: sequences the
// training/feedback/update windows over several passes and owns the coefficient bank.
module dpd_lms_adapt #(
    parameter int W         = 20,
    parameter int CW        = 20,
    parameter int NCOEF     = 15,
    parameter int DELAY     = 41,
    parameter int TRAIN_LEN = 800,
    parameter int UPD_START = 150,
    parameter int UPD_END   = 700,
    parameter int N_INIT    = 3,
    parameter int INIT_RE   = 349500
) (
    input  logic           clk,
    input  logic           reset,
    dpd_lms_adapt_if.slave bus
);
    localparam int CNT_W = $clog2(DELAY + TRAIN_LEN + 1);
    localparam int EW    = W + 1;       // error width: difference of two W-bit samples
    localparam int PW    = 2 * W + 2;   // full-precision complex product
    localparam int SW    = PW + 1;      // accumulator sum before saturation

    localparam logic [CNT_W-1:0] TR_LO = CNT_W'(1);
    localparam logic [CNT_W-1:0] TR_HI = CNT_W'(TRAIN_LEN);
    localparam logic [CNT_W-1:0] FB_LO = CNT_W'(DELAY + 1);
    localparam logic [CNT_W-1:0] FB_HI = CNT_W'(DELAY + TRAIN_LEN);
    localparam logic [CNT_W-1:0] UP_LO = CNT_W'(DELAY + UPD_START);
    localparam logic [CNT_W-1:0] UP_HI = CNT_W'(DELAY + UPD_END);

    localparam logic signed [SW-1:0] SAT_HI = SW'((longint'(1) <<< (CW - 1)) - 1);
    localparam logic signed [SW-1:0] SAT_LO = -SAT_HI - SW'(1);
    localparam logic signed [CW-1:0] C_MAX  = SAT_HI[CW-1:0];
    localparam logic signed [CW-1:0] C_MIN  = SAT_LO[CW-1:0];
    localparam logic signed [CW-1:0] INIT_C = CW'(INIT_RE);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [3:0]       iter_q, n_iter_q;
    logic [4:0]       mu_q;
    logic             train_en_q, sw_fb_q, upd_win_q, phase_q;
    logic             run;

    assign run = (state_q == S_RUN);

    // Windows and phase are registered from the current count, so they lag cnt by one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            iter_q     <= '0;
            n_iter_q   <= '0;
            mu_q       <= '0;
            train_en_q <= 1'b0;
            sw_fb_q    <= 1'b0;
            upd_win_q  <= 1'b0;
            phase_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every term reads pre-edge state.
            train_en_q <= run && (cnt_q >= TR_LO) && (cnt_q <= TR_HI);
            sw_fb_q    <= run && (cnt_q >= FB_LO) && (cnt_q <= FB_HI);
            upd_win_q  <= run && (cnt_q >= UP_LO) && (cnt_q <= UP_HI);
            phase_q    <= run && (cnt_q != '0) && !phase_q;
            case (state_q)
                S_IDLE: begin
                    if (bus.start) begin
                        state_q  <= S_RUN;
                        cnt_q    <= '0;
                        iter_q   <= '0;
                        n_iter_q <= bus.n_iter;
                        mu_q     <= bus.mu_shift;
                    end
                end
                S_RUN: begin
                    if (cnt_q == FB_HI) begin
                        cnt_q <= '0;
                        if (iter_q == n_iter_q) state_q <= S_DONE;
                        else                    iter_q  <= iter_q + 4'd1;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Stage A: conjugated, step-scaled error and the basis vector captured together.
    logic signed [EW-1:0] e_i, e_q, ec_i_d, ec_q_d, ec_i_q, ec_q_q;
    logic signed [W-1:0]  ya_i_q [NCOEF];
    logic signed [W-1:0]  ya_q_q [NCOEF];
    logic                 va_q, upd_go;

    assign upd_go = phase_q && upd_win_q;

    always_comb begin
        e_i    = {bus.ref_i[W-1], bus.ref_i} - {bus.fb_i[W-1], bus.fb_i};
        e_q    = {bus.ref_q[W-1], bus.ref_q} - {bus.fb_q[W-1], bus.fb_q};
        ec_i_d = e_i >>> mu_q;
        ec_q_d = (-e_q) >>> mu_q;
    end

    always_ff @(posedge clk) begin
        if (reset || !upd_go) begin
            va_q   <= 1'b0;
            ec_i_q <= '0;
            ec_q_q <= '0;
            for (int k = 0; k < NCOEF; k++) begin
                ya_i_q[k] <= '0;
                ya_q_q[k] <= '0;
            end
        end else begin
            va_q   <= 1'b1;
            ec_i_q <= ec_i_d;
            ec_q_q <= ec_q_d;
            for (int k = 0; k < NCOEF; k++) begin
                ya_i_q[k] <= bus.yy_i[k*W +: W];
                ya_q_q[k] <= bus.yy_q[k*W +: W];
            end
        end
    end

    // Stage B: complex product yy_k * ec, rescaled by the basis full-scale.
    logic signed [PW-1:0] pb_i_d [NCOEF];
    logic signed [PW-1:0] pb_q_d [NCOEF];
    logic signed [PW-1:0] pb_i_q [NCOEF];
    logic signed [PW-1:0] pb_q_q [NCOEF];
    logic                 vb_q;

    always_comb begin
        for (int k = 0; k < NCOEF; k++) begin
            pb_i_d[k] = (PW'(ya_i_q[k]) * PW'(ec_i_q) - PW'(ya_q_q[k]) * PW'(ec_q_q)) >>> (W - 1);
            pb_q_d[k] = (PW'(ya_i_q[k]) * PW'(ec_q_q) + PW'(ya_q_q[k]) * PW'(ec_i_q)) >>> (W - 1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vb_q <= 1'b0;
            for (int k = 0; k < NCOEF; k++) begin
                pb_i_q[k] <= '0;
                pb_q_q[k] <= '0;
            end
        end else begin
            vb_q <= va_q;
            for (int k = 0; k < NCOEF; k++) begin
                pb_i_q[k] <= pb_i_d[k];
                pb_q_q[k] <= pb_q_d[k];
            end
        end
    end

    // Stage C: saturating accumulate into the coefficient bank.
    logic signed [CW-1:0] c_i_q [NCOEF];
    logic signed [CW-1:0] c_q_q [NCOEF];
    logic signed [CW-1:0] c_i_d [NCOEF];
    logic signed [CW-1:0] c_q_d [NCOEF];
    logic signed [CW-1:0] cq_out_q [NCOEF];
    logic                 clear_go;

    assign clear_go = (state_q == S_IDLE) && bus.clear_coef;

    function automatic logic signed [CW-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_HI) return C_MAX;
        if (v < SAT_LO) return C_MIN;
        return v[CW-1:0];
    endfunction

    function automatic logic signed [CW-1:0] neg_sat(input logic signed [CW-1:0] v);
        return (v == C_MIN) ? C_MAX : -v;
    endfunction

    function automatic logic signed [CW-1:0] init_re(input int k);
        return (k < N_INIT) ? INIT_C : '0;
    endfunction

    always_comb begin
        for (int k = 0; k < NCOEF; k++) begin
            // NOTE: hold value assigned first so no path leaves the bank unassigned (no latch).
            c_i_d[k] = c_i_q[k];
            c_q_d[k] = c_q_q[k];
            if (clear_go) begin
                c_i_d[k] = init_re(k);
                c_q_d[k] = '0;
            end else if (vb_q) begin
                c_i_d[k] = sat(SW'(c_i_q[k]) + SW'(pb_i_q[k]));
                c_q_d[k] = sat(SW'(c_q_q[k]) + SW'(pb_q_q[k]));
            end
        end
    end

    // NOTE: the bank is flops, not RAM, so it takes a real reset value.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < NCOEF; k++) begin
                c_i_q[k]    <= init_re(k);
                c_q_q[k]    <= '0;
                cq_out_q[k] <= '0;
            end
        end else begin
            for (int k = 0; k < NCOEF; k++) begin
                c_i_q[k]    <= c_i_d[k];
                c_q_q[k]    <= c_q_d[k];
                cq_out_q[k] <= neg_sat(c_q_d[k]);
            end
        end
    end

    for (genvar k = 0; k < NCOEF; k++) begin : g_coef
        assign bus.coef_i[k*CW +: CW] = c_i_q[k];
        assign bus.coef_q[k*CW +: CW] = cq_out_q[k];
    end

    assign bus.train_en = train_en_q;
    assign bus.sw_fb    = sw_fb_q;
    assign bus.busy     = run;
    assign bus.done     = (state_q == S_DONE);
    assign bus.iter_cnt = iter_q;
endmodule

// File: tb/tb_dpd_lms_adapt.sv
// Self-checking bench for dpd_lms_adapt: a longint reference model predicts the bank
// for each run, the prediction is queued at start and compared when done pulses.
module tb_dpd_lms_adapt;
    localparam int W         = 20;
    localparam int CW        = 20;
    localparam int NCOEF     = 15;
    localparam int DELAY     = 41;
    localparam int TRAIN_LEN = 800;
    localparam int UPD_START = 150;
    localparam int UPD_END   = 700;
    localparam int N_INIT    = 3;
    localparam int INIT_RE   = 349500;
    localparam int PASS_LEN  = DELAY + TRAIN_LEN + 1;
    localparam longint CMAX  = (longint'(1) <<< (CW - 1)) - 1;
    localparam longint CMIN  = -CMAX - 1;

    logic clk = 1'b0;
    logic reset;

    dpd_lms_adapt_if #(.W(W), .CW(CW), .NCOEF(NCOEF)) bus ();

    dpd_lms_adapt #(
        .W(W), .CW(CW), .NCOEF(NCOEF), .DELAY(DELAY), .TRAIN_LEN(TRAIN_LEN),
        .UPD_START(UPD_START), .UPD_END(UPD_END), .N_INIT(N_INIT), .INIT_RE(INIT_RE)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [NCOEF*CW-1:0] ci;
        logic [NCOEF*CW-1:0] cq;
    } exp_t;

    exp_t   sb_q[$];
    int     n_total = 0;
    int     n_bad   = 0;
    longint s_ref_i, s_ref_q, s_fb_i, s_fb_q;
    longint s_yy_i [NCOEF];
    longint s_yy_q [NCOEF];
    longint m_ci   [NCOEF];
    longint m_cq   [NCOEF];

    task automatic check(input string tag, input longint got, input longint exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    function automatic longint rnd_s(input int bits);
        return longint'($urandom_range((1 << bits) - 1, 0)) - (longint'(1) << (bits - 1));
    endfunction

    function automatic longint clamp(input longint v);
        if (v > CMAX) return CMAX;
        if (v < CMIN) return CMIN;
        return v;
    endfunction

    function automatic int updates_per_pass();
        int n = 0;
        for (int c = DELAY + UPD_START; c <= DELAY + UPD_END; c++)
            if (c % 2 == 1) n++;
        return n;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NCOEF; k++) begin
            m_ci[k] = (k < N_INIT) ? longint'(INIT_RE) : 0;
            m_cq[k] = 0;
        end
    endtask

    task automatic model_run(input int passes, input int mu);
        longint ec_i, ec_q, p_i, p_q;
        ec_i = (s_ref_i - s_fb_i) >>> mu;
        ec_q = (-(s_ref_q - s_fb_q)) >>> mu;
        repeat (passes * updates_per_pass()) begin
            for (int k = 0; k < NCOEF; k++) begin
                p_i = (s_yy_i[k] * ec_i - s_yy_q[k] * ec_q) >>> (W - 1);
                p_q = (s_yy_i[k] * ec_q + s_yy_q[k] * ec_i) >>> (W - 1);
                m_ci[k] = clamp(m_ci[k] + p_i);
                m_cq[k] = clamp(m_cq[k] + p_q);
            end
        end
    endtask

    function automatic exp_t expect_now();
        exp_t e;
        for (int k = 0; k < NCOEF; k++) begin
            e.ci[k*CW +: CW] = CW'(m_ci[k]);
            e.cq[k*CW +: CW] = CW'((m_cq[k] == CMIN) ? CMAX : -m_cq[k]);
        end
        return e;
    endfunction

    task automatic check_coefs(input string tag, input exp_t e);
        for (int k = 0; k < NCOEF; k++) begin
            check($sformatf("%s coef_i[%0d]", tag, k),
                  longint'($signed(bus.coef_i[k*CW +: CW])), longint'($signed(e.ci[k*CW +: CW])));
            check($sformatf("%s coef_q[%0d]", tag, k),
                  longint'($signed(bus.coef_q[k*CW +: CW])), longint'($signed(e.cq[k*CW +: CW])));
        end
    endtask

    task automatic drive_inputs();
        bus.ref_i = W'(s_ref_i);
        bus.ref_q = W'(s_ref_q);
        bus.fb_i  = W'(s_fb_i);
        bus.fb_q  = W'(s_fb_q);
        for (int k = 0; k < NCOEF; k++) begin
            bus.yy_i[k*W +: W] = W'(s_yy_i[k]);
            bus.yy_q[k*W +: W] = W'(s_yy_q[k]);
        end
    endtask

    task automatic clear_yy();
        for (int k = 0; k < NCOEF; k++) begin
            s_yy_i[k] = 0;
            s_yy_q[k] = 0;
        end
    endtask

    // j counts samples after the start edge; the cycle that presents start is j=0.
    task automatic do_run(input string tag, input int ni, input int mu, input bit clr,
                          input int poke_at, input int watch_k, input int exp_chg);
        exp_t       e;
        int         passes = ni + 1;
        int         busy_n = 0, tr_n = 0, sw_n = 0, done_n = 0, steps = 0, chg_n = 0;
        int         tr_first = -1, sw_first = -1, done_at = -1;
        logic [3:0] last_iter = '0;
        logic [CW-1:0] prev = '0;
        if (clr) model_reset();
        model_run(passes, mu);
        sb_q.push_back(expect_now());
        drive_inputs();
        @(negedge clk);
        bus.n_iter     = 4'(ni);
        bus.mu_shift   = 5'(mu);
        bus.start      = 1'b1;
        bus.clear_coef = clr;
        for (int j = 1; j <= passes * PASS_LEN + 10; j++) begin
            @(negedge clk);
            if (j == 1) begin
                bus.start      = 1'b0;
                bus.clear_coef = 1'b0;
                check({tag, " iter_cnt at start"}, bus.iter_cnt, 0);
                last_iter = bus.iter_cnt;
                prev      = bus.coef_i[watch_k*CW +: CW];
            end else begin
                if (bus.iter_cnt != last_iter) begin
                    steps++;
                    last_iter = bus.iter_cnt;
                end
                if (bus.coef_i[watch_k*CW +: CW] != prev) begin
                    chg_n++;
                    prev = bus.coef_i[watch_k*CW +: CW];
                end
            end
            if (j == poke_at) begin
                bus.start      = 1'b1;
                bus.clear_coef = 1'b1;
            end else if (j == poke_at + 1) begin
                bus.start      = 1'b0;
                bus.clear_coef = 1'b0;
            end
            if (bus.busy) busy_n++;
            if (bus.train_en) begin
                tr_n++;
                if (tr_first < 0) tr_first = j;
            end
            if (bus.sw_fb) begin
                sw_n++;
                if (sw_first < 0) sw_first = j;
            end
            if (bus.done) begin
                done_n++;
                if (done_at < 0) done_at = j;
                if (sb_q.size() > 0) begin
                    e = sb_q.pop_front();
                    check_coefs(tag, e);
                end
            end
        end
        check({tag, " done seen"}, (done_at > 0) ? 1 : 0, 1);
        check({tag, " busy cycles"}, busy_n, passes * PASS_LEN);
        check({tag, " done pulses"}, done_n, 1);
        check({tag, " done cycle"}, done_at, passes * PASS_LEN + 1);
        check({tag, " train_en cycles"}, tr_n, passes * TRAIN_LEN);
        check({tag, " train_en first"}, tr_first, 3);
        check({tag, " sw_fb cycles"}, sw_n, passes * TRAIN_LEN);
        check({tag, " sw_fb first"}, sw_first, DELAY + 3);
        check({tag, " iter steps"}, steps, ni);
        check({tag, " last iter"}, last_iter, ni);
        if (exp_chg >= 0) check({tag, " coef updates"}, chg_n, exp_chg);
    endtask

    task automatic do_abort();
        int done_n = 0, busy_n = 0;
        clear_yy();
        s_fb_i = -20000; s_ref_i = 30000; s_fb_q = 0; s_ref_q = 0;
        s_yy_i[0] = 300000;
        drive_inputs();
        @(negedge clk);
        bus.n_iter   = 4'd3;
        bus.mu_shift = 5'd0;
        bus.start    = 1'b1;
        for (int j = 1; j <= 301; j++) begin
            @(negedge clk);
            if (j == 1) bus.start = 1'b0;
        end
        check("abort coef moved", (longint'($signed(bus.coef_i[0 +: CW])) != INIT_RE) ? 1 : 0, 1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", bus.busy, 0);
        check("abort iter_cnt", bus.iter_cnt, 0);
        check("abort train_en", bus.train_en, 0);
        model_reset();
        check_coefs("abort", expect_now());
        for (int j = 0; j < PASS_LEN + 50; j++) begin
            @(negedge clk);
            if (bus.done) done_n++;
            if (bus.busy) busy_n++;
        end
        check("abort done pulses", done_n, 0);
        check("abort busy after", busy_n, 0);
        check_coefs("abort settled", expect_now());
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset          = 1'b1;
        bus.start      = 1'b0;
        bus.clear_coef = 1'b0;
        bus.n_iter     = '0;
        bus.mu_shift   = '0;
        s_ref_i = 0; s_ref_q = 0; s_fb_i = 0; s_fb_q = 0;
        clear_yy();
        drive_inputs();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        model_reset();
        check_coefs("reset", expect_now());
        check("reset busy", bus.busy, 0);
        check("reset done", bus.done, 0);
        check("reset train_en", bus.train_en, 0);
        check("reset sw_fb", bus.sw_fb, 0);
        check("reset iter_cnt", bus.iter_cnt, 0);

        // Zero error: the bank must not move.
        s_fb_i = rnd_s(W); s_fb_q = rnd_s(W);
        s_ref_i = s_fb_i;  s_ref_q = s_fb_q;
        for (int k = 0; k < NCOEF; k++) begin
            s_yy_i[k] = rnd_s(W);
            s_yy_q[k] = rnd_s(W);
        end
        do_run("zero_err", 0, 2, 1'b0, 0, 0, 0);

        // Real error of 4096 on a full-scale basis element: +511 per update.
        clear_yy();
        s_fb_i = 1000; s_ref_i = 5096; s_fb_q = -777; s_ref_q = -777;
        s_yy_i[3] = (longint'(1) << (W - 1)) - 1;
        do_run("step511", 0, 3, 1'b0, 0, 3, 276);
        check("step511 coef_i[3] value", longint'($signed(bus.coef_i[3*CW +: CW])), 276 * 511);

        // Random complex error over two passes, with start+clear poked mid-run.
        s_fb_i = rnd_s(W - 1); s_fb_q = rnd_s(W - 1);
        s_ref_i = s_fb_i + rnd_s(12); s_ref_q = s_fb_q + rnd_s(12);
        for (int k = 0; k < NCOEF; k++) begin
            s_yy_i[k] = rnd_s(W);
            s_yy_q[k] = rnd_s(W);
        end
        do_run("complex", 1, 4, 1'b0, 500, 0, -1);

        // Large constant error over three passes drives both saturation rails.
        clear_yy();
        s_ref_i = (longint'(1) << (W - 1)) - 1; s_fb_i = -(longint'(1) << (W - 1));
        s_ref_q = 0; s_fb_q = 0;
        s_yy_i[0] = (longint'(1) << (W - 1)) - 1;
        s_yy_i[1] = -(longint'(1) << (W - 1));
        s_yy_q[2] = -(longint'(1) << (W - 1));
        do_run("saturate", 2, 0, 1'b0, 0, 0, -1);
        check("saturate coef_i[0] rail", longint'($signed(bus.coef_i[0 +: CW])), CMAX);
        check("saturate coef_i[1] rail", longint'($signed(bus.coef_i[CW +: CW])), CMIN);
        check("saturate coef_q[2] neg rail", longint'($signed(bus.coef_q[2*CW +: CW])), CMAX);

        // Start together with clear in IDLE: run begins from the initial bank.
        clear_yy();
        s_fb_i = 1000; s_ref_i = 5096; s_fb_q = 0; s_ref_q = 0;
        s_yy_i[3] = (longint'(1) << (W - 1)) - 1;
        do_run("start_clear", 0, 5, 1'b1, 0, 3, 276);
        check("start_clear coef_i[3] value", longint'($signed(bus.coef_i[3*CW +: CW])), 276 * 127);

        do_abort();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end
endmodule
